// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter/sequencer for the shared data_mem of the matrix-multiplier
//   core. Port A is the compute core, port B the host/matrix loader. Each
//   granted request is one memory beat: writes take IDLE->ISSUE, reads take
//   IDLE->ISSUE->CAPTURE with the read data returned through *_rdata/*_rvalid.
//
//   Build option: DMEM_ARB_RR_EN
//     defined   - round-robin on a tie (the port that did not win last wins)
//     undefined - fixed priority on a tie (port B always wins)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   a_*/b_* req,we,addr,wdata request side (held until *_gnt)
//   a_*/b_* gnt,rvalid,rdata  grant pulse, read-valid pulse, read data
//   busy                      high whenever the sequencer is not IDLE
//   mem_we,mem_w_addr,
//   mem_w_data,mem_r_addr     drive data_mem (w_data is 16 bits, zero-extended)
//   mem_r_data                data_mem registered read data
//
// State    | meaning
// IDLE     | waiting; picks a winner and registers its request
// ISSUE    | mem_* driven, winner's gnt pulsed; writes commit here
// CAPTURE  | read address held, mem_r_data captured at end of cycle
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_w_addr,
  output logic [15:0]   mem_w_data,
  output logic [AW-1:0] mem_r_addr,
  input  logic [DW-1:0] mem_r_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t        state;
  logic          sel_b;
  logic          we_q;
  logic [DW-1:0] w_data_q;

  logic          tie_b;
  logic          pick_b;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

`ifdef DMEM_ARB_RR_EN
  // Set when B is preferred on the next tie; flips to the loser on every grant.
  logic rr_b;
  assign tie_b = rr_b;
`else
  assign tie_b = 1'b1;
`endif

  assign pick_b    = b_req & (~a_req | tie_b);
  assign win_we    = pick_b ? b_we    : a_we;
  assign win_addr  = pick_b ? b_addr  : a_addr;
  assign win_wdata = pick_b ? b_wdata : a_wdata;

  assign mem_w_data = 16'(w_data_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel_b      <= 1'b0;
      we_q       <= 1'b0;
      w_data_q   <= '0;
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      mem_w_addr <= '0;
      mem_r_addr <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_b       <= 1'b0;
`endif
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            state <= ISSUE;
            busy  <= 1'b1;
            sel_b <= pick_b;
            we_q  <= win_we;
            a_gnt <= ~pick_b;
            b_gnt <= pick_b;
            // Only the address/data of the side being used moves; the other
            // side keeps its last value.
            if (win_we) begin
              mem_we     <= 1'b1;
              mem_w_addr <= win_addr;
              w_data_q   <= win_wdata;
            end else begin
              mem_r_addr <= win_addr;
            end
`ifdef DMEM_ARB_RR_EN
            rr_b <= ~pick_b;
`endif
          end
        end
        ISSUE: begin
          if (we_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (sel_b) begin
            b_rdata  <= mem_r_data;
            b_rvalid <= 1'b1;
          end else begin
            a_rdata  <= mem_r_data;
            a_rvalid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a data_mem stand-in (registered read),
//   a cycle-timeline reference model and a per-cycle output compare.
//   Build option DMEM_ARB_RR_EN must match the one used for the DUT.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [7:0]  a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, busy, mem_we;
  logic [7:0]  a_rdata, b_rdata, mem_w_addr, mem_r_addr;
  logic [15:0] mem_w_data;
  logic [7:0]  mem_r_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .busy(busy), .mem_we(mem_we), .mem_w_addr(mem_w_addr),
    .mem_w_data(mem_w_data), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // data_mem stand-in: synchronous write, registered read
  logic [7:0] dmem [256];
  logic       dmem_init = 1'b0;
  always @(posedge clk) begin
    if (!dmem_init) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'(i) ^ 8'h5A;
      dmem_init <= 1'b1;
    end else begin
      if (mem_we) dmem[mem_w_addr] <= mem_w_data[7:0];
      mem_r_data <= dmem[mem_r_addr];
    end
  end

  // Reference model: each accepted request is placed on a cycle timeline
  // (grant at +1, idle again at +2 for a write / +3 for a read, rvalid at +3).
  logic [7:0]  ref_mem [256];
  bit          ref_init = 0;
  bit          model_ok = 0;
  int          cyc = 0, free_at = 0, rv_at = -1;
  bit          rv_port;
  logic [7:0]  rv_addr;
  bit          win_b, tie_b;
`ifdef DMEM_ARB_RR_EN
  bit          rr_b = 0;
`endif
  logic        exp_a_gnt = 0, exp_b_gnt = 0, exp_a_rvalid = 0, exp_b_rvalid = 0;
  logic        exp_busy = 0, exp_mem_we = 0;
  logic [7:0]  exp_a_rdata = 0, exp_b_rdata = 0, exp_w_addr = 0, exp_r_addr = 0;
  logic [15:0] exp_w_data = 0;

  always @(posedge clk) begin
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
      ref_init = 1;
    end
    if (exp_mem_we) ref_mem[exp_w_addr] = exp_w_data[7:0];
    exp_a_gnt = 0; exp_b_gnt = 0; exp_a_rvalid = 0; exp_b_rvalid = 0; exp_mem_we = 0;
    if (rst) begin
      exp_busy = 0; exp_a_rdata = 0; exp_b_rdata = 0;
      exp_w_addr = 0; exp_r_addr = 0; exp_w_data = 0;
      free_at = cyc + 1; rv_at = -1; model_ok = 1;
`ifdef DMEM_ARB_RR_EN
      rr_b = 0;
`endif
    end else begin
      if (cyc + 1 == rv_at) begin
        if (rv_port) begin exp_b_rvalid = 1; exp_b_rdata = ref_mem[rv_addr]; end
        else         begin exp_a_rvalid = 1; exp_a_rdata = ref_mem[rv_addr]; end
      end
      if (cyc >= free_at && (a_req || b_req)) begin
`ifdef DMEM_ARB_RR_EN
        tie_b = rr_b;
`else
        tie_b = 1;
`endif
        win_b = b_req && (!a_req || tie_b);
        if (win_b) exp_b_gnt = 1; else exp_a_gnt = 1;
        if (win_b ? b_we : a_we) begin
          exp_mem_we = 1;
          exp_w_addr = win_b ? b_addr : a_addr;
          exp_w_data = {8'h00, (win_b ? b_wdata : a_wdata)};
          free_at = cyc + 2;
        end else begin
          exp_r_addr = win_b ? b_addr : a_addr;
          free_at = cyc + 3;
          rv_at   = cyc + 3;
          rv_port = win_b;
          rv_addr = exp_r_addr;
        end
`ifdef DMEM_ARB_RR_EN
        rr_b = !win_b;
`endif
      end
      exp_busy = (cyc + 1 < free_at);
    end
    cyc++;
  end

  // Per-cycle compare plus grant-order log
  bit glog [$];
  always @(negedge clk) begin
    if (model_ok) begin
      chk("a_gnt", a_gnt, exp_a_gnt);
      chk("b_gnt", b_gnt, exp_b_gnt);
      chk("a_rvalid", a_rvalid, exp_a_rvalid);
      chk("b_rvalid", b_rvalid, exp_b_rvalid);
      chk("a_rdata", a_rdata, exp_a_rdata);
      chk("b_rdata", b_rdata, exp_b_rdata);
      chk("busy", busy, exp_busy);
      chk("mem_we", mem_we, exp_mem_we);
      chk("mem_w_addr", mem_w_addr, exp_w_addr);
      chk("mem_w_data", mem_w_data, exp_w_data);
      chk("mem_r_addr", mem_r_addr, exp_r_addr);
    end
    if (a_gnt === 1'b1) glog.push_back(1'b0);
    if (b_gnt === 1'b1) glog.push_back(1'b1);
  end

  // Called at a negedge; raises the request immediately and returns at the
  // negedge where gnt (write) or rvalid (read) is observed.
  task automatic xfer(input bit port, input bit we, input logic [7:0] addr,
                      input logic [7:0] wd, output logic [7:0] rd, output int lat);
    bit got;
    if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    lat = 0; got = 0; rd = '0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); lat++;
      got = port ? b_gnt : a_gnt;
    end
    if (port) b_req = 0; else a_req = 0;
    chk(port ? "b_gnt_wait" : "a_gnt_wait", 32'(got), 1);
    if (!we && got) begin
      got = 0;
      for (int n = 0; n < 10 && !got; n++) begin
        @(negedge clk); lat++;
        got = port ? b_rvalid : a_rvalid;
      end
      chk(port ? "b_rvalid_wait" : "a_rvalid_wait", 32'(got), 1);
      rd = port ? b_rdata : a_rdata;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd, rd_a, rd_b;
    int lat, lat_a, lat_b;
    logic [7:0] order, exp_order;
    bit got;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_a_rdata", a_rdata, 0);

    // A writes 0x0F to 0x1E, then reads it back
    xfer(1'b0, 1'b1, 8'h1E, 8'h0F, rd, lat);
    chk("wr_lat", lat, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_w_addr", mem_w_addr, 8'h1E);
    chk("wr_w_data", mem_w_data, 16'h000F);
    @(negedge clk);
    xfer(1'b0, 1'b0, 8'h1E, 8'h00, rd, lat);
    chk("rd_lat", lat, 3);
    chk("rd_data", rd, 8'h0F);

    // Simultaneous writes from both ports after a fresh reset
    do_reset();
    glog.delete();
    fork
      xfer(1'b0, 1'b1, 8'h1F, 8'h10, rd_a, lat_a);
      xfer(1'b1, 1'b1, 8'h20, 8'h11, rd_b, lat_b);
    join
    @(negedge clk);
    chk("tie_count", glog.size(), 2);
`ifdef DMEM_ARB_RR_EN
    chk("tie_first", glog[0], 0);
`else
    chk("tie_first", glog[0], 1);
`endif

    // Four back-to-back reads of 0..3 on each port
    do_reset();
    glog.delete();
    fork
      begin
        logic [7:0] r; int l;
        for (int i = 0; i < 4; i++) begin
          xfer(1'b0, 1'b0, 8'(i), 8'h00, r, l);
          chk("a_stream_data", r, 8'(i) ^ 8'h5A);
        end
      end
      begin
        logic [7:0] r; int l;
        for (int i = 0; i < 4; i++) begin
          xfer(1'b1, 1'b0, 8'(i), 8'h00, r, l);
          chk("b_stream_data", r, 8'(i) ^ 8'h5A);
        end
      end
    join
    @(negedge clk);
    chk("stream_count", glog.size(), 8);
    order = '0;
    for (int i = 0; i < 8 && i < glog.size(); i++) order[i] = glog[i];
`ifdef DMEM_ARB_RR_EN
    exp_order = 8'b1010_1010;
`else
    exp_order = 8'b0000_1111;
`endif
    chk("stream_order", order, exp_order);

    // Reset during the CAPTURE cycle of an A read
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 8'h02;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = a_gnt;
    end
    a_req = 0;
    chk("rst_gnt_wait", 32'(got), 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("rst_a_rdata", a_rdata, 0);
    xfer(1'b0, 1'b0, 8'h02, 8'h00, rd, lat);
    chk("post_rst_data", rd, 8'h58);
    chk("post_rst_lat", lat, 3);

    // B writes 0x22 to 0x05 while A has a read of 0x05 pending
    glog.delete();
    fork
      xfer(1'b1, 1'b1, 8'h05, 8'h22, rd_b, lat_b);
      begin
        @(negedge clk);
        xfer(1'b0, 1'b0, 8'h05, 8'h00, rd_a, lat_a);
      end
    join
    @(negedge clk);
    chk("raw_count", glog.size(), 2);
    chk("raw_first_b", glog[0], 1);
    chk("raw_data", rd_a, 8'h22);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
